// File: rtl/hps_cfg_pkg.sv
// Shared types and constants for the HPS user-I/O config block and its
// strobe generator.
package hps_cfg_pkg;

  localparam int CFG_W = 16;

  localparam logic [7:0] DEF_WR_CMD = 8'h01;
  localparam logic [7:0] DEF_RD_CMD = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_SKIP = 2'd3
  } state_t;

endpackage

// File: rtl/hps_io_strobe.sv
// Turns the HPS io_clk level into a single-cycle event and a registered
// acknowledge that downstream logic can hold off with io_wait.
module hps_io_strobe (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic io_clk,
  input  logic io_wait,
  output logic strobe,
  output logic evt,
  output logic io_ack
);

  logic rack;
  logic strobe_d;

  assign strobe = io_clk & ~rack;
  assign evt    = strobe & ~strobe_d;

  // A fresh strobe is always captured; afterwards io_wait freezes the ack path.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rack     <= 1'b0;
      io_ack   <= 1'b0;
      strobe_d <= 1'b0;
    end else begin
      strobe_d <= strobe;
      if (!io_wait || strobe) begin
        rack   <= io_clk;
        io_ack <= rack;
      end
    end
  end

endmodule

// File: rtl/hps_uio_cfg.sv
// Decodes HPS user-I/O command frames: multi-word writes are staged in a shadow
// bank and committed atomically at frame end; read frames stream cfg back.
// Handshake: each io_clk rising level is one word; io_ack follows two cycles
// later unless io_wait holds it, and io_dout is valid one cycle before io_ack.
module hps_uio_cfg
  import hps_cfg_pkg::*;
#(
  parameter int         NWORDS = 4,
  parameter logic [7:0] WR_CMD = DEF_WR_CMD,
  parameter logic [7:0] RD_CMD = DEF_RD_CMD
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     io_uio,
  input  logic                     io_clk,
  input  logic [CFG_W-1:0]         io_din,
  input  logic                     io_wait,
  output logic                     io_ack,
  output logic [CFG_W-1:0]         io_dout,
  output logic [CFG_W*NWORDS-1:0]  cfg,
  output logic                     cfg_update,
  output logic                     cfg_ready,
  output state_t                   dbg_state
);

  localparam int             IW   = $clog2(NWORDS + 1);
  localparam logic [IW-1:0]  NW_I = IW'(NWORDS);

  logic             strobe;
  logic             evt;
  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic             dirty, dirty_n;
  logic [CFG_W-1:0] dout_n;
  logic [CFG_W-1:0] rd_word;
  logic             shadow_we;
  logic             commit;
  logic [CFG_W-1:0] shadow [NWORDS];
  logic [CFG_W-1:0] cfg_q  [NWORDS];

  hps_io_strobe u_strobe (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .io_clk  (io_clk),
    .io_wait (io_wait),
    .strobe  (strobe),
    .evt     (evt),
    .io_ack  (io_ack)
  );

  assign dbg_state = state;

  for (genvar g = 0; g < NWORDS; g++) begin : g_cfg
    assign cfg[g*CFG_W +: CFG_W] = cfg_q[g];
  end

  // Word following the current read index; zero past the end of the bank.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx + 1'b1 == IW'(k)) rd_word = cfg_q[k];
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    dirty_n   = dirty;
    dout_n    = io_dout;
    shadow_we = 1'b0;
    commit    = 1'b0;
    if (!io_uio) begin
      // Frame end outranks any strobe arriving in the same cycle.
      state_n = ST_IDLE;
      dout_n  = '0;
      commit  = (state == ST_WR) && dirty;
    end else if (evt) begin
      case (state)
        ST_IDLE: begin
          idx_n = '0;
          if (io_din[7:0] == WR_CMD) begin
            state_n = ST_WR;
            dirty_n = 1'b0;
          end else if (io_din[7:0] == RD_CMD) begin
            state_n = ST_RD;
            dout_n  = cfg_q[0];
          end else begin
            state_n = ST_SKIP;
          end
        end
        ST_WR: begin
          if (idx < NW_I) begin
            shadow_we = 1'b1;
            dirty_n   = 1'b1;
            idx_n     = idx + 1'b1;
          end
        end
        ST_RD: begin
          if (idx < NW_I) begin
            idx_n  = idx + 1'b1;
            dout_n = rd_word;
          end else begin
            dout_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      dirty      <= 1'b0;
      io_dout    <= '0;
      cfg_update <= 1'b0;
      cfg_ready  <= 1'b0;
      for (int k = 0; k < NWORDS; k++) begin
        shadow[k] <= '0;
        cfg_q[k]  <= '0;
      end
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dirty      <= dirty_n;
      io_dout    <= dout_n;
      cfg_update <= commit;
      if (commit) begin
        cfg_ready <= 1'b1;
        for (int k = 0; k < NWORDS; k++) cfg_q[k] <= shadow[k];
      end
      for (int k = 0; k < NWORDS; k++) begin
        if (shadow_we && idx == IW'(k)) shadow[k] <= io_din;
      end
    end
  end

endmodule

// File: tb/tb_hps_uio_cfg.sv
// Bench for hps_uio_cfg: directed frames plus random frames checked against a
// frame-level model of the committed config words.
module tb_hps_uio_cfg;
  import hps_cfg_pkg::*;

  localparam int NW = 4;
  localparam int CW = CFG_W * NW;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          io_uio  = 1'b0;
  logic          io_clk  = 1'b0;
  logic          io_wait = 1'b0;
  logic [15:0]   io_din  = '0;
  logic          io_ack;
  logic [15:0]   io_dout;
  logic [CW-1:0] cfg;
  logic          cfg_update;
  logic          cfg_ready;
  state_t        dbg_state;

  hps_uio_cfg #(.NWORDS(NW)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .io_uio     (io_uio),
    .io_clk     (io_clk),
    .io_din     (io_din),
    .io_wait    (io_wait),
    .io_ack     (io_ack),
    .io_dout    (io_dout),
    .cfg        (cfg),
    .cfg_update (cfg_update),
    .cfg_ready  (cfg_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks  = 0;
  int          errors  = 0;
  int          upd_cnt = 0;
  logic [15:0] cfg_m [NW];
  bit          ready_m;
  logic [15:0] exp_q [$];

  always @(negedge clk_sys) if (cfg_update === 1'b1) upd_cnt++;

  function automatic logic [CW-1:0] model_cfg();
    logic [CW-1:0] r;
    for (int k = 0; k < NW; k++) r[16*k +: 16] = cfg_m[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One HPS strobe; returns io_dout as seen the cycle before io_ack rises.
  task automatic strobe_word(input logic [15:0] d, output logic [15:0] dout_early);
    io_din = d;
    io_clk = 1'b1;
    tick();
    dout_early = io_dout;
    chk("ack_before_data", CW'(io_ack), CW'(1'b0));
    tick();
    chk("ack_rise", CW'(io_ack), CW'(1'b1));
    io_clk = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] w [8], input int n);
    int          base;
    bit          do_commit;
    logic [15:0] d;
    logic [15:0] e;
    io_uio = 1'b1;
    tick();
    base = upd_cnt;
    if (cmd == 8'h02)
      for (int k = 0; k <= n; k++) exp_q.push_back(k < NW ? cfg_m[k] : 16'h0000);
    strobe_word({8'h00, cmd}, d);
    if (cmd == 8'h02) begin
      e = exp_q.pop_front();
      chk("rd_word0", CW'(d), CW'(e));
    end
    for (int i = 0; i < n; i++) begin
      strobe_word(w[i], d);
      if (cmd == 8'h02) begin
        e = exp_q.pop_front();
        chk($sformatf("rd_word%0d", i + 1), CW'(d), CW'(e));
      end
    end
    chk("cfg_before_end", cfg, model_cfg());
    do_commit = (cmd == 8'h01) && (n > 0);
    if (do_commit) begin
      for (int i = 0; i < n && i < NW; i++) cfg_m[i] = w[i];
      ready_m = 1'b1;
    end
    io_uio = 1'b0;
    tick();
    chk("cfg_at_commit", cfg, model_cfg());
    chk("update_pulse", CW'(cfg_update), CW'(do_commit));
    tick();
    chk("update_low", CW'(cfg_update), CW'(1'b0));
    chk("update_count", CW'(upd_cnt - base), CW'(do_commit));
    chk("ready", CW'(cfg_ready), CW'(ready_m));
    chk("dout_after_end", CW'(io_dout), CW'(16'h0000));
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] w [8];
  logic [15:0] dd;

  initial begin
    for (int k = 0; k < NW; k++) cfg_m[k] = '0;
    ready_m = 1'b0;

    // Reset values
    #12;
    chk("rst_cfg", cfg, '0);
    chk("rst_ready", CW'(cfg_ready), CW'(1'b0));
    chk("rst_update", CW'(cfg_update), CW'(1'b0));
    chk("rst_ack", CW'(io_ack), CW'(1'b0));
    chk("rst_dout", CW'(io_dout), CW'(16'h0000));
    chk("rst_state", CW'(dbg_state), CW'(ST_IDLE));
    reset_n = 1'b1;
    tick();

    // Two-word write into a four-word bank
    w[0] = 16'h1234; w[1] = 16'hABCD;
    run_frame(8'h01, w, 2);

    // Six words: the last two overflow and are dropped
    for (int i = 0; i < 6; i++) w[i] = 16'(i + 1);
    run_frame(8'h01, w, 6);

    // Read back with five trailing dummy strobes
    for (int i = 0; i < 5; i++) w[i] = 16'h5A5A;
    run_frame(8'h02, w, 5);

    // Unknown command swallows its data; empty write frame does not commit
    w[0] = 16'hFFFF;
    run_frame(8'h07, w, 1);
    run_frame(8'h01, w, 0);

    // Strobe coinciding with frame end is dropped
    io_uio = 1'b1;
    tick();
    strobe_word(16'h0001, dd);
    strobe_word(16'hAAAA, dd);
    io_din = 16'hBBBB;
    io_clk = 1'b1;
    io_uio = 1'b0;
    tick();
    cfg_m[0] = 16'hAAAA;
    chk("drop_on_end", cfg, model_cfg());
    io_clk = 1'b0;
    repeat (3) tick();
    chk("drop_on_end_after", cfg, model_cfg());

    // io_wait holds the acknowledge; io_wait drops at edge E0 and ack rises at E1
    io_wait = 1'b1;
    io_clk  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("wait_hold%0d", i), CW'(io_ack), CW'(1'b0));
    end
    io_wait = 1'b0;
    chk("wait_release_e0", CW'(io_ack), CW'(1'b0));
    tick();
    chk("wait_release_e1", CW'(io_ack), CW'(1'b1));
    io_clk = 1'b0;
    repeat (3) tick();
    chk("wait_ack_drop", CW'(io_ack), CW'(1'b0));

    // Asynchronous reset mid-frame, while io_ack is high
    io_uio = 1'b1;
    tick();
    strobe_word(16'h0001, dd);
    strobe_word(16'h1111, dd);
    strobe_word(16'h2222, dd);
    io_din = 16'h3333;
    io_clk = 1'b1;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < NW; k++) cfg_m[k] = '0;
    ready_m = 1'b0;
    chk("arst_cfg", cfg, '0);
    chk("arst_ready", CW'(cfg_ready), CW'(1'b0));
    chk("arst_ack", CW'(io_ack), CW'(1'b0));
    chk("arst_dout", CW'(io_dout), CW'(16'h0000));
    chk("arst_state", CW'(dbg_state), CW'(ST_IDLE));
    io_clk = 1'b0;
    io_uio = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    w[0] = 16'hC0DE; w[1] = 16'hBEEF; w[2] = 16'h0F0F; w[3] = 16'h7777;
    run_frame(8'h01, w, 4);

    // Random frames against the model
    for (int f = 0; f < 12; f++) begin
      logic [7:0] cmd;
      int         n;
      case ($urandom_range(0, 3))
        0, 1:    cmd = 8'h01;
        2:       cmd = 8'h02;
        default: cmd = 8'(8'h10 + $urandom_range(0, 200));
      endcase
      n = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      run_frame(cmd, w, n);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
